// File: rtl/master_cpu_debug_pkg.sv
// Shared defaults, instruction encodings and synchroniser depth for the CPU debug
// command path between the TCK-side JTAG logic and the OCI control blocks.
package master_cpu_debug_pkg;

  localparam int unsigned DefaultIrWidth = 2;
  localparam int unsigned DefaultDrWidth = 38;
  localparam int unsigned SyncStages     = 3;

  typedef enum logic [1:0] {
    IrOcimem    = 2'd0,
    IrTracemem  = 2'd1,
    IrBreak     = 2'd2,
    IrTracectrl = 2'd3
  } debug_ir_e;

endpackage

// File: rtl/master_cpu_debug_toggle_sync.sv
// Brings a TCK-domain toggle into the system clock domain and turns each change into a
// one-cycle edge strobe, suppressed until the chain has refilled after reset.
module master_cpu_debug_toggle_sync
  import master_cpu_debug_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic edge_o
);

  localparam int unsigned ArmWidth = $clog2(SyncStages + 1);
  localparam logic [ArmWidth-1:0] ArmDone = ArmWidth'(SyncStages);

  logic [SyncStages-1:0] sync_q;
  logic [ArmWidth-1:0]   arm_q, arm_d;
  logic                  armed;

  assign armed = (arm_q == ArmDone);
  assign arm_d = armed ? arm_q : arm_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], tgl_i};
      arm_q  <= arm_d;
    end
  end

  // A toggle resting at 1 looks like an edge while the zeroed chain refills; masked.
  assign edge_o = armed & (sync_q[SyncStages-2] ^ sync_q[SyncStages-1]);

endmodule

// File: rtl/master_cpu_debug_cmd_sysclk.sv
// System-clock command receiver: snapshots {IR, DR} on each synchronised Update-DR,
// queues it in a small FIFO and presents it with per-instruction action strobes.
module master_cpu_debug_cmd_sysclk
  import master_cpu_debug_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = DefaultIrWidth,
  parameter int unsigned DR_WIDTH   = DefaultDrWidth,
  parameter int unsigned ACTION_BIT = DR_WIDTH - 1,
  parameter int unsigned CMD_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [IR_WIDTH-1:0]                tck_ir_in,
  input  logic [DR_WIDTH-1:0]                tck_sr,
  input  logic                               tck_udr_tgl,
  input  logic                               tck_uir_tgl,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [IR_WIDTH-1:0]                cmd_ir,
  output logic [DR_WIDTH-1:0]                cmd_jdo,
  output logic [(1 << IR_WIDTH)-1:0]         take_action,
  output logic [(1 << IR_WIDTH)-1:0]         take_no_action,
  output logic                               uir_pulse,
  output logic [$clog2(CMD_DEPTH + 1)-1:0]   fifo_level,
  output logic                               overflow,
  input  logic                               overflow_clr
);

  localparam int unsigned AddrWidth  = $clog2(CMD_DEPTH);
  localparam int unsigned PtrWidth   = AddrWidth + 1;
  localparam int unsigned LvlWidth   = $clog2(CMD_DEPTH + 1);
  localparam int unsigned EntryWidth = IR_WIDTH + DR_WIDTH;

  logic                  dr_edge;
  logic [EntryWidth-1:0] mem_q [CMD_DEPTH];
  logic [EntryWidth-1:0] head;
  logic [PtrWidth-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, push, pop, drop;

  master_cpu_debug_toggle_sync u_uir_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .tgl_i  (tck_uir_tgl),
    .edge_o (uir_pulse)
  );

  master_cpu_debug_toggle_sync u_udr_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .tgl_i  (tck_udr_tgl),
    .edge_o (dr_edge)
  );

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrWidth-1:0] == rptr_q[AddrWidth-1:0]) &&
                 (wptr_q[AddrWidth] != rptr_q[AddrWidth]);
  assign pop   = cmd_valid & cmd_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign push  = dr_edge & (~full | pop);
  assign drop  = dr_edge & full & ~pop;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AddrWidth-1:0]] <= {tck_ir_in, tck_sr};
  end

  assign head       = mem_q[rptr_q[AddrWidth-1:0]];
  assign cmd_valid  = ~empty;
  assign cmd_ir     = empty ? '0 : head[DR_WIDTH +: IR_WIDTH];
  assign cmd_jdo    = empty ? '0 : head[DR_WIDTH-1:0];
  assign fifo_level = LvlWidth'(wptr_q - rptr_q);
  assign overflow   = overflow_q;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (cmd_jdo[ACTION_BIT]) take_action[cmd_ir]    = 1'b1;
      else                     take_no_action[cmd_ir] = 1'b1;
    end
  end

endmodule

// File: tb/tb_master_cpu_debug_cmd_sysclk.sv
// Randomised and directed bench for the debug command receiver, checked every cycle
// against a queue-based model of toggle timing and FIFO behaviour.
module tb_master_cpu_debug_cmd_sysclk;
  import master_cpu_debug_pkg::*;

  localparam int IRW   = 2;
  localparam int DRW   = 38;
  localparam int DEPTH = 4;
  localparam int ACT   = DRW - 1;
  localparam int NCMD  = 4;
  localparam int LVLW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [IRW-1:0]  tck_ir_in;
  logic [DRW-1:0]  tck_sr;
  logic            tck_udr_tgl, tck_uir_tgl;
  logic            cmd_valid, cmd_ready;
  logic [IRW-1:0]  cmd_ir;
  logic [DRW-1:0]  cmd_jdo;
  logic [NCMD-1:0] take_action, take_no_action;
  logic            uir_pulse;
  logic [LVLW-1:0] fifo_level;
  logic            overflow, overflow_clr;

  always #5 clk = ~clk;

  master_cpu_debug_cmd_sysclk #(
    .IR_WIDTH   (IRW),
    .DR_WIDTH   (DRW),
    .ACTION_BIT (ACT),
    .CMD_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tck_ir_in      (tck_ir_in),
    .tck_sr         (tck_sr),
    .tck_udr_tgl    (tck_udr_tgl),
    .tck_uir_tgl    (tck_uir_tgl),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_jdo        (cmd_jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .uir_pulse      (uir_pulse),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DRW-1:0] rnd_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DRW-1:0];
  endfunction

  // Model: a change between consecutive post-reset samples taken at edge N yields a FIFO
  // write at edge N+2 (DR) or a pulse in the N+1 -> N+2 cycle (IR).
  logic [IRW+DRW-1:0] mq[$];
  int                 dr_due[$];
  int                 ir_due[$];
  int                 idx = 0;
  bit                 started = 0;
  bit                 m_ovf, m_uir, do_wr, do_pop, was_full;
  logic               last_udr, last_uir;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      dr_due.delete();
      ir_due.delete();
      m_ovf   = 0;
      m_uir   = 0;
      idx     = 0;
      started = 1;
    end else begin
      do_wr = (dr_due.size() > 0) && (dr_due[0] == idx);
      if (do_wr) void'(dr_due.pop_front());
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && (cmd_ready == 1'b1);
      if (do_pop) void'(mq.pop_front());
      if (do_wr && was_full && !do_pop) m_ovf = 1;
      else begin
        if (do_wr) mq.push_back({tck_ir_in, tck_sr});
        if (overflow_clr) m_ovf = 0;
      end
      if (idx > 0 && tck_udr_tgl != last_udr) dr_due.push_back(idx + 2);
      if (idx > 0 && tck_uir_tgl != last_uir) ir_due.push_back(idx + 1);
      last_udr = tck_udr_tgl;
      last_uir = tck_uir_tgl;
      m_uir = (ir_due.size() > 0) && (ir_due[0] == idx);
      if (m_uir) void'(ir_due.pop_front());
      idx++;
    end
  end

  logic [IRW+DRW-1:0] exp_head;
  logic [NCMD-1:0]    exp_ta, exp_tna;
  logic [IRW-1:0]     hir;
  bit                 exp_valid;

  initial forever begin
    @(negedge clk);
    if (started) begin
      exp_valid = (mq.size() > 0);
      exp_head  = exp_valid ? mq[0] : '0;
      hir       = exp_head[DRW +: IRW];
      exp_ta    = '0;
      exp_tna   = '0;
      if (exp_valid && cmd_ready === 1'b1) begin
        if (exp_head[ACT]) exp_ta[hir] = 1'b1;
        else               exp_tna[hir] = 1'b1;
      end
      chk("m_valid", 64'(cmd_valid), 64'(exp_valid));
      chk("m_ir", 64'(cmd_ir), 64'(hir));
      chk("m_jdo", 64'(cmd_jdo), 64'(exp_head[DRW-1:0]));
      chk("m_level", 64'(fifo_level), 64'(mq.size()));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
      chk("m_uir", 64'(uir_pulse), 64'(m_uir));
      chk("m_take", 64'(take_action), 64'(exp_ta));
      chk("m_notake", 64'(take_no_action), 64'(exp_tna));
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      cyc1();
      if (cmd_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [DRW-1:0] vals [5];
  int             lat;
  int             bias;

  initial begin
    reset = 1; tck_udr_tgl = 1; tck_uir_tgl = 0; tck_ir_in = '0; tck_sr = '0;
    cmd_ready = 0; overflow_clr = 0;
    repeat (3) cyc1();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      cyc1();
      chk("idle_valid", 64'(cmd_valid), 64'd0);
    end
    chk("idle_level", 64'(fifo_level), 64'd0);
    chk("idle_ovf", 64'(overflow), 64'd0);

    tck_ir_in = IrBreak; tck_sr = 38'h20_0000_0001; tck_udr_tgl = ~tck_udr_tgl;
    wait_valid(lat);
    chk("b_latency", 64'(lat), 64'd3);
    chk("b_jdo", 64'(cmd_jdo), 64'h20_0000_0001);
    chk("b_ir", 64'(cmd_ir), 64'd2);
    cmd_ready = 1; #1;
    chk("b_take", 64'(take_action), 64'b0100);
    chk("b_notake", 64'(take_no_action), 64'd0);
    cyc1(); cmd_ready = 0; #1;
    chk("b_drained", 64'(cmd_valid), 64'd0);
    chk("b_take_off", 64'(take_action), 64'd0);

    tck_ir_in = IrOcimem; tck_sr = 38'h0_1234_5678; tck_udr_tgl = ~tck_udr_tgl;
    wait_valid(lat);
    chk("c_latency", 64'(lat), 64'd3);
    cmd_ready = 1; #1;
    chk("c_notake", 64'(take_no_action), 64'b0001);
    chk("c_take", 64'(take_action), 64'd0);
    cyc1(); cmd_ready = 0;

    tck_uir_tgl = ~tck_uir_tgl;
    cyc1(); chk("uir_early", 64'(uir_pulse), 64'd0);
    cyc1(); chk("uir_pulse", 64'(uir_pulse), 64'd1);
    cyc1(); chk("uir_once", 64'(uir_pulse), 64'd0);

    for (int i = 0; i < 5; i++) begin
      tck_ir_in = IrTracemem; vals[i] = rnd_sr(); tck_sr = vals[i];
      tck_udr_tgl = ~tck_udr_tgl;
      repeat (4) cyc1();
    end
    repeat (2) cyc1();
    chk("d_level", 64'(fifo_level), 64'd4);
    chk("d_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cmd_ready = 1; #1;
      chk("d_order", 64'(cmd_jdo), 64'(vals[i]));
      cyc1();
    end
    cmd_ready = 0; #1;
    chk("d_empty", 64'(fifo_level), 64'd0);
    cmd_ready = 1; cyc1(); cmd_ready = 0;
    chk("d_empty_ready", 64'(fifo_level), 64'd0);

    overflow_clr = 1; cyc1(); overflow_clr = 0;
    for (int i = 0; i < 4; i++) begin
      tck_sr = rnd_sr(); tck_udr_tgl = ~tck_udr_tgl;
      repeat (4) cyc1();
    end
    chk("e_full", 64'(fifo_level), 64'd4);
    tck_sr = rnd_sr(); tck_udr_tgl = ~tck_udr_tgl;
    cyc1(); cyc1(); cmd_ready = 1; cyc1(); cmd_ready = 0; #1;
    chk("e_level_same", 64'(fifo_level), 64'd4);
    chk("e_no_ovf", 64'(overflow), 64'd0);
    tck_sr = rnd_sr(); tck_udr_tgl = ~tck_udr_tgl;
    cyc1(); cyc1(); overflow_clr = 1; cyc1(); overflow_clr = 0; #1;
    chk("e_set_wins", 64'(overflow), 64'd1);
    chk("e_level_kept", 64'(fifo_level), 64'd4);

    cmd_ready = 1; cyc1(); cmd_ready = 0; #1;
    chk("f_level3", 64'(fifo_level), 64'd3);
    reset = 1; cyc1();
    chk("f_rst_valid", 64'(cmd_valid), 64'd0);
    chk("f_rst_level", 64'(fifo_level), 64'd0);
    chk("f_rst_ovf", 64'(overflow), 64'd0);
    chk("f_rst_jdo", 64'(cmd_jdo), 64'd0);
    reset = 0; tck_udr_tgl = ~tck_udr_tgl;
    repeat (6) cyc1();
    chk("f_ignored", 64'(cmd_valid), 64'd0);
    tck_sr = rnd_sr(); tck_udr_tgl = ~tck_udr_tgl;
    wait_valid(lat);
    chk("f_rearmed", 64'(lat), 64'd3);
    cmd_ready = 1; cyc1(); cmd_ready = 0;

    bias = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 80 == 0) bias = $urandom_range(0, 4);
      reset        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) tck_udr_tgl = ~tck_udr_tgl;
      if ($urandom_range(0, 5) == 0) tck_uir_tgl = ~tck_uir_tgl;
      tck_ir_in    = IRW'($urandom_range(0, 3));
      tck_sr       = rnd_sr();
      cmd_ready    = ($urandom_range(0, 3) < bias);
      overflow_clr = ($urandom_range(0, 19) == 0);
      cyc1();
    end
    reset = 0; cmd_ready = 0; overflow_clr = 0;
    repeat (3) cyc1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
